// File: rtl/adbg_syncflop_multi.sv
// Multi-channel toggle-to-pulse synchroniser into DEST_CLK with sticky flags and saturating overrun counters.
// Latency: TOGGLE_IN sampled at edge n gives PULSE_OUT in the cycle after edge n+SYNC_STAGES-1; no backpressure.
module adbg_syncflop_multi #(
    parameter int CHANNELS    = 4,
    parameter int SYNC_STAGES = 2,
    parameter int CNT_W       = 4
) (
    input  logic                      DEST_CLK,
    input  logic                      RESET,
    input  logic [CHANNELS-1:0]       TOGGLE_IN,
    input  logic [CHANNELS-1:0]       D_SET,
    input  logic [CHANNELS-1:0]       D_RST,
    output logic [CHANNELS-1:0]       PULSE_OUT,
    output logic [CHANNELS-1:0]       D_OUT,
    output logic [CHANNELS*CNT_W-1:0] OVR_CNT,
    output logic                      ANY_OUT
);

    localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

    for (genvar i = 0; i < CHANNELS; i++) begin : g_ch
        // Bit 0 is the metastability-catching flop; bit SYNC_STAGES-1 feeds the edge detector.
        (* ASYNC_REG = "TRUE" *) logic [SYNC_STAGES-1:0] sync_q;
        logic             prev_q;
        logic             flag_q;
        logic             flag_d;
        logic [CNT_W-1:0] cnt_q;
        logic [CNT_W-1:0] cnt_d;
        logic             pulse;

        assign pulse = sync_q[SYNC_STAGES-1] ^ prev_q;

        always_comb begin
            flag_d = flag_q;
            cnt_d  = cnt_q;
            if (D_RST[i]) begin
                flag_d = 1'b0;
                cnt_d  = '0;
            end else begin
                if (pulse || D_SET[i]) begin
                    flag_d = 1'b1;
                end
                // Overrun only when the event lands on an already-set flag.
                if (pulse && flag_q && (cnt_q != CNT_MAX)) begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
        end

        always_ff @(posedge DEST_CLK or posedge RESET) begin
            if (RESET) begin
                sync_q <= '0;
                prev_q <= 1'b0;
                flag_q <= 1'b0;
                cnt_q  <= '0;
            end else begin
                sync_q <= {sync_q[SYNC_STAGES-2:0], TOGGLE_IN[i]};
                prev_q <= sync_q[SYNC_STAGES-1];
                flag_q <= flag_d;
                cnt_q  <= cnt_d;
            end
        end

        assign PULSE_OUT[i]                = pulse;
        assign D_OUT[i]                    = flag_q | pulse;
        assign OVR_CNT[i*CNT_W +: CNT_W]   = cnt_q;
    end

    assign ANY_OUT = |D_OUT;

endmodule

// File: tb/tb_adbg_syncflop_multi.sv
// Directed bench for adbg_syncflop_multi: a default instance (2 stages, 4-bit counters)
// and a 3-stage, 2-bit-counter, 2-channel instance for latency, saturation and mid-chain reset.
module tb_adbg_syncflop_multi;

    logic        clk = 1'b0;
    always #5 clk = ~clk;

    // Default instance
    logic        rst;
    logic [3:0]  tog, dset, drst;
    logic [3:0]  pulse, dout;
    logic [15:0] ovr;
    logic        any;

    // 3-stage instance
    logic        rst3;
    logic [1:0]  tog3, dset3, drst3;
    logic [1:0]  pulse3, dout3;
    logic [3:0]  ovr3;
    logic        any3;

    int n_checks = 0;
    int n_errors = 0;

    adbg_syncflop_multi dut (
        .DEST_CLK (clk),
        .RESET    (rst),
        .TOGGLE_IN(tog),
        .D_SET    (dset),
        .D_RST    (drst),
        .PULSE_OUT(pulse),
        .D_OUT    (dout),
        .OVR_CNT  (ovr),
        .ANY_OUT  (any)
    );

    adbg_syncflop_multi #(.CHANNELS(2), .SYNC_STAGES(3), .CNT_W(2)) dut3 (
        .DEST_CLK (clk),
        .RESET    (rst3),
        .TOGGLE_IN(tog3),
        .D_SET    (dset3),
        .D_RST    (drst3),
        .PULSE_OUT(pulse3),
        .D_OUT    (dout3),
        .OVR_CNT  (ovr3),
        .ANY_OUT  (any3)
    );

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Drive and sample 1 time unit after the rising edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        rst  = 1'b1; tog  = '0; dset  = '0; drst  = '0;
        rst3 = 1'b1; tog3 = '0; dset3 = '0; drst3 = '0;
        #2;
        check_eq("rst_pulse", 32'(pulse), 0);
        check_eq("rst_dout",  32'(dout),  0);
        check_eq("rst_ovr",   32'(ovr),   0);
        check_eq("rst_any",   32'(any),   0);
        tick(); tick();
        rst = 1'b0; rst3 = 1'b0;
        tick(); tick();

        // Two-stage latency on ch0
        tog[0] = 1'b1;
        tick();
        check_eq("lat2_early", 32'(pulse[0]), 0);
        tick();
        check_eq("lat2_pulse", 32'(pulse), 32'h1);
        check_eq("lat2_dout",  32'(dout[0]), 1);
        check_eq("lat2_any",   32'(any), 1);
        tick();
        check_eq("lat2_end",   32'(pulse[0]), 0);
        check_eq("lat2_hold",  32'(dout[0]), 1);
        check_eq("lat2_ovr0",  32'(ovr[3:0]), 0);

        // ch1: flag forced, then three overruns, then clear
        dset = 4'b0010;
        tick();
        dset = '0;
        check_eq("ch1_set",     32'(dout[1]), 1);
        check_eq("ch1_set_ovr", 32'(ovr[7:4]), 0);
        for (int k = 1; k <= 3; k++) begin
            tog[1] = ~tog[1];
            tick(); tick();
            check_eq("ch1_pulse", 32'(pulse[1]), 1);
            tick(); tick();
            check_eq("ch1_ovr", 32'(ovr[7:4]), 32'(k));
        end
        drst = 4'b0010;
        tick();
        drst = '0;
        check_eq("ch1_rst_dout", 32'(dout[1]), 0);
        check_eq("ch1_rst_ovr",  32'(ovr[7:4]), 0);

        // ch2: D_RST lands exactly in the pulse cycle with the flag set
        dset = 4'b0100;
        tick();
        dset = '0;
        tog[2] = 1'b1;
        tick(); tick();
        drst = 4'b0100;
        #1;
        check_eq("ch2_pulse_vis", 32'(pulse[2]), 1);
        check_eq("ch2_dout_vis",  32'(dout[2]), 1);
        tick();
        drst = '0;
        check_eq("ch2_dout_clr", 32'(dout[2]), 0);
        check_eq("ch2_ovr_clr",  32'(ovr[11:8]), 0);
        tick();
        check_eq("ch2_stay_clr", 32'(dout[2]), 0);

        // ch3: D_SET alone does not count; subsequent toggle does
        dset = 4'b1000;
        tick();
        dset = '0;
        check_eq("ch3_set",     32'(dout[3]), 1);
        check_eq("ch3_set_ovr", 32'(ovr[15:12]), 0);
        tog[3] = 1'b1;
        tick(); tick(); tick(); tick();
        check_eq("ch3_ovr1", 32'(ovr[15:12]), 1);
        check_eq("indep_ovr", 32'(ovr[11:0]), 0);

        drst = 4'hF;
        tick();
        drst = '0;
        check_eq("all_clr_dout", 32'(dout), 0);
        check_eq("all_clr_any",  32'(any), 0);

        // Three-stage latency is one cycle longer
        tog3[0] = 1'b1;
        tick(); tick();
        check_eq("lat3_early", 32'(pulse3[0]), 0);
        tick();
        check_eq("lat3_pulse", 32'(pulse3), 32'h1);
        tick();
        check_eq("lat3_end",  32'(pulse3[0]), 0);
        check_eq("lat3_hold", 32'(dout3[0]), 1);

        // 2-bit counter saturates at 3
        for (int k = 1; k <= 6; k++) begin
            tog3[0] = ~tog3[0];
            tick(); tick(); tick(); tick();
            check_eq("sat_ovr", 32'(ovr3[1:0]), (k < 3) ? 32'(k) : 32'd3);
        end
        check_eq("sat_ch1", 32'(ovr3[3:2]), 0);

        // Reset while a toggle is in flight on ch1
        tog3[1] = 1'b1;
        tick();
        #2;
        rst3 = 1'b1;
        tog3 = '0;
        #1;
        check_eq("mid_rst_dout", 32'(dout3), 0);
        check_eq("mid_rst_ovr",  32'(ovr3), 0);
        check_eq("mid_rst_any",  32'(any3), 0);
        tick(); tick();
        rst3 = 1'b0;
        for (int k = 0; k < 5; k++) begin
            tick();
            check_eq("post_rst_pulse", 32'(pulse3), 0);
            check_eq("post_rst_dout",  32'(dout3), 0);
        end
        check_eq("post_rst_ovr", 32'(ovr3), 0);
        check_eq("post_rst_any", 32'(any3), 0);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
